hmac_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single HMAC-SHA3-512 engine message port among NUM_REQ independent requesters. Sits between the secure key system's HMAC interface and client blocks. Gates all grants on PUF key validity, sequences the HMAC start, stream and wait phases for one requester at a time, and routes the 512-bit result back. A watchdog aborts hung transactions.

---
 rtl/hmac_req_arbiter_pkg.sv | 15 +
 rtl/hmac_req_arbiter_if.sv | 33 +++
 rtl/hmac_req_arbiter_rr_arbiter.sv | 36 +++
 rtl/hmac_req_arbiter.sv | 165 ++++++++++++++++
 tb/tb_hmac_req_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hmac_req_arbiter_pkg.sv
// Shared state encoding and width constants for the HMAC requester arbiter.
package hmac_arb_pkg;

    localparam int WORD_W          = 32;
    localparam int HMAC_W          = 512;
    localparam int DEFAULT_TIMEOUT = 4096;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_STREAM = 2'd2,
        S_WAIT   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/hmac_req_arbiter_if.sv
// Message/result port of the shared HMAC engine; the arbiter is master, the engine is slave.
interface hmac_req_arbiter_if;
    import hmac_arb_pkg::*;

    logic              start_hmac;
    logic [WORD_W-1:0] msg_word;
    logic              msg_valid;
    logic              msg_last;
    logic              msg_ready;
    logic [HMAC_W-1:0] hmac_value;
    logic              hmac_done;

    modport master (
        output start_hmac,
        output msg_word,
        output msg_valid,
        output msg_last,
        input  msg_ready,
        input  hmac_value,
        input  hmac_done
    );

    modport slave (
        input  start_hmac,
        input  msg_word,
        input  msg_valid,
        input  msg_last,
        output msg_ready,
        output hmac_value,
        output hmac_done
    );

endinterface

// File: rtl/hmac_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first active request strictly after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_next,
    output logic [IDX_W-1:0]   gnt_idx
);

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    // ptr itself is visited last, so the previous winner has lowest priority.
    always_comb begin
        gnt_next = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        sum      = '0;
        cand_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum      = {1'b0, ptr} + (IDX_W+1)'(i);
            cand_idx = IDX_W'((sum >= NUM_REQ_W) ? (sum - NUM_REQ_W) : sum);
            if (!found && req[cand_idx]) begin
                found              = 1'b1;
                gnt_next[cand_idx] = 1'b1;
                gnt_idx            = cand_idx;
            end
        end
    end

endmodule

// File: rtl/hmac_req_arbiter.sv
// Shares the HMAC engine message port among NUM_REQ requesters: arbitration, sequencing, watchdog, result return.
module hmac_req_arbiter
    import hmac_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      key_valid,
    input  logic [NUM_REQ-1:0]        req,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic [NUM_REQ*WORD_W-1:0] req_msg_word,
    input  logic [NUM_REQ-1:0]        req_msg_valid,
    input  logic [NUM_REQ-1:0]        req_msg_last,
    output logic [NUM_REQ-1:0]        req_msg_ready,
    output logic [NUM_REQ-1:0]        rsp_done,
    output logic [NUM_REQ-1:0]        rsp_err,
    output logic [HMAC_W-1:0]         rsp_hmac,
    output logic                      busy,
    hmac_req_arbiter_if.master        eng
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    arb_state_e state, state_d;

    logic [IDX_W-1:0]   ptr, ptr_d;
    logic [IDX_W-1:0]   gidx, gidx_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [NUM_REQ-1:0] done_d, err_d;
    logic [HMAC_W-1:0]  hmac_d;
    logic               start_q, start_d;
    logic               busy_d;
    logic [WD_W-1:0]    wd_cnt, wd_d, wd_inc;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic [WORD_W-1:0]  word_arr [NUM_REQ];
    logic               streaming;
    logic               beat;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req      (req),
        .ptr      (ptr),
        .gnt_next (arb_gnt),
        .gnt_idx  (arb_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            word_arr[i] = req_msg_word[i*WORD_W +: WORD_W];
        end
    end

    // Message path is a pure mux so the engine sees the granted requester with no added latency.
    assign streaming     = (state == S_STREAM);
    assign eng.msg_word  = streaming ? word_arr[gidx] : '0;
    assign eng.msg_valid = streaming & (|(req_msg_valid & gnt));
    assign eng.msg_last  = streaming & (|(req_msg_last & gnt));
    assign req_msg_ready = streaming ? (gnt & {NUM_REQ{eng.msg_ready}}) : '0;
    assign eng.start_hmac = start_q;
    assign beat          = eng.msg_valid & eng.msg_ready;

    // Watchdog saturates at the limit so it can never wrap back into range.
    assign wd_inc = (wd_cnt == WD_LIMIT) ? wd_cnt : (wd_cnt + WD_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        gidx_d  = gidx;
        ptr_d   = ptr;
        wd_d    = wd_cnt;
        start_d = 1'b0;
        done_d  = '0;
        err_d   = '0;
        hmac_d  = rsp_hmac;

        // Losing the key invalidates any transaction in flight, including one finishing this cycle.
        if ((state != S_IDLE) && !key_valid) begin
            err_d   = gnt;
            gnt_d   = '0;
            ptr_d   = gidx;
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (key_valid && (|req)) begin
                        gnt_d   = arb_gnt;
                        gidx_d  = arb_idx;
                        start_d = 1'b1;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    state_d = S_STREAM;
                end
                S_STREAM: begin
                    if (beat && eng.msg_last) begin
                        wd_d    = '0;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    wd_d = wd_inc;
                    if (eng.hmac_done) begin
                        hmac_d  = eng.hmac_value;
                        done_d  = gnt;
                        gnt_d   = '0;
                        ptr_d   = gidx;
                        state_d = S_IDLE;
                    end else if (wd_inc == WD_LIMIT) begin
                        err_d   = gnt;
                        gnt_d   = '0;
                        ptr_d   = gidx;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt      <= '0;
            gidx     <= '0;
            ptr      <= IDX_W'(NUM_REQ - 1);
            wd_cnt   <= '0;
            start_q  <= 1'b0;
            rsp_done <= '0;
            rsp_err  <= '0;
            rsp_hmac <= '0;
            busy     <= 1'b0;
        end else begin
            gnt      <= gnt_d;
            gidx     <= gidx_d;
            ptr      <= ptr_d;
            wd_cnt   <= wd_d;
            start_q  <= start_d;
            rsp_done <= done_d;
            rsp_err  <= err_d;
            rsp_hmac <= hmac_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_hmac_req_arbiter.sv
// Directed self-checking bench for hmac_req_arbiter; a second instance with TIMEOUT=16 covers the watchdog.
module tb_hmac_req_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic [3:0]   req;
    logic [127:0] req_msg_word;
    logic [3:0]   req_msg_valid;
    logic [3:0]   req_msg_last;

    logic [3:0]   gnt, req_msg_ready, rsp_done, rsp_err;
    logic [511:0] rsp_hmac;
    logic         busy;

    logic [3:0]   w_gnt, w_req_msg_ready, w_rsp_done, w_rsp_err;
    logic [511:0] w_rsp_hmac;
    logic         w_busy;

    int n_checks  = 0;
    int n_fail    = 0;
    int start_cnt = 0;
    int done1_cnt = 0;

    hmac_req_arbiter_if eng ();
    hmac_req_arbiter_if weng ();

    hmac_req_arbiter #(.NUM_REQ(4), .TIMEOUT(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_valid     (key_valid),
        .req           (req),
        .gnt           (gnt),
        .req_msg_word  (req_msg_word),
        .req_msg_valid (req_msg_valid),
        .req_msg_last  (req_msg_last),
        .req_msg_ready (req_msg_ready),
        .rsp_done      (rsp_done),
        .rsp_err       (rsp_err),
        .rsp_hmac      (rsp_hmac),
        .busy          (busy),
        .eng           (eng)
    );

    hmac_req_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut_wd (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_valid     (key_valid),
        .req           (req),
        .gnt           (w_gnt),
        .req_msg_word  (req_msg_word),
        .req_msg_valid (req_msg_valid),
        .req_msg_last  (req_msg_last),
        .req_msg_ready (w_req_msg_ready),
        .rsp_done      (w_rsp_done),
        .rsp_err       (w_rsp_err),
        .rsp_hmac      (w_rsp_hmac),
        .busy          (w_busy),
        .eng           (weng)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (eng.start_hmac === 1'b1) start_cnt <= start_cnt + 1;
        if (rsp_done[1] === 1'b1)    done1_cnt <= done1_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_valid = 1'b1;
        req = 4'b1111;
        req_msg_valid = 4'b1111;
        req_msg_last = 4'b1111;
        req_msg_word = '1;
        eng.msg_ready = 1'b1;  eng.hmac_done = 1'b1;  eng.hmac_value = '1;
        weng.msg_ready = 1'b1; weng.hmac_done = 1'b1; weng.hmac_value = '1;
        tick();
        tick();
        n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (eng.start_hmac !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_start: got %b expected 0", eng.start_hmac); end
        n_checks++; if (rsp_done !== 4'b0000 || rsp_err !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_rsp: done %b err %b expected 0000 0000", rsp_done, rsp_err); end
        n_checks++; if (rsp_hmac !== 512'd0) begin n_fail++; $display("[TB] FAIL reset_hmac: got %h expected 0", rsp_hmac); end
        n_checks++; if (eng.msg_valid !== 1'b0 || eng.msg_last !== 1'b0 || eng.msg_word !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_msg: valid %b last %b word %h expected 0 0 0", eng.msg_valid, eng.msg_last, eng.msg_word); end
        n_checks++; if (req_msg_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 0000", req_msg_ready); end
    endtask

    task automatic test_single();
        logic [31:0]  words [3];
        logic [31:0]  got [3];
        logic [511:0] v;
        int n, idx, ncyc, s0, d0;
        bit fin;
        words = '{32'h11111111, 32'h22222222, 32'h33333333};
        got   = '{32'h0, 32'h0, 32'h0};
        v     = {8{64'h0123456789ABCDEF}};
        s0 = start_cnt;
        d0 = done1_cnt;
        key_valid = 1'b1;
        req = 4'b0010;
        req_msg_valid = 4'b0010;
        req_msg_last = 4'b0000;
        req_msg_word = '0;
        req_msg_word[63:32] = words[0];
        eng.msg_ready = 1'b1;
        eng.hmac_done = 1'b0;
        eng.hmac_value = '0;
        rst_n = 1'b1;
        tick();
        n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("[TB] FAIL single_gnt: got %b expected 0010", gnt); end
        n_checks++; if (eng.start_hmac !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL single_start: start %b busy %b expected 1 1", eng.start_hmac, busy); end
        tick();
        req = 4'b0000;
        n = 0; idx = 0; ncyc = 0; fin = 1'b0;
        while (!fin && ncyc < 10) begin
            #1;
            if (eng.msg_valid === 1'b1 && eng.msg_ready === 1'b1) begin
                if (n < 3) got[n] = eng.msg_word;
                n++;
                idx++;
                if (eng.msg_last === 1'b1) fin = 1'b1;
            end
            ncyc++;
            tick();
            if (!fin && idx < 3) begin
                req_msg_word[63:32] = words[idx];
                req_msg_last[1] = (idx == 2);
            end
        end
        n_checks++; if (n !== 3 || ncyc !== 3) begin n_fail++; $display("[TB] FAIL single_beats: got %0d beats in %0d cycles expected 3 in 3", n, ncyc); end
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (got[k] !== words[k]) begin n_fail++; $display("[TB] FAIL single_word%0d: got %h expected %h", k, got[k], words[k]); end
        end
        n_checks++; if (busy !== 1'b1 || gnt !== 4'b0010) begin n_fail++; $display("[TB] FAIL single_wait: busy %b gnt %b expected 1 0010", busy, gnt); end
        repeat (19) tick();
        eng.hmac_value = v;
        eng.hmac_done = 1'b1;
        tick();
        eng.hmac_done = 1'b0;
        n_checks++; if (rsp_done !== 4'b0010 || rsp_err !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_done: done %b err %b expected 0010 0000", rsp_done, rsp_err); end
        n_checks++; if (rsp_hmac !== v) begin n_fail++; $display("[TB] FAIL single_hmac: got %h expected %h", rsp_hmac, v); end
        n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_idle: gnt %b busy %b expected 0000 0", gnt, busy); end
        tick();
        n_checks++; if (start_cnt - s0 !== 1 || done1_cnt - d0 !== 1) begin n_fail++; $display("[TB] FAIL single_pulses: start %0d done %0d expected 1 1", start_cnt - s0, done1_cnt - d0); end
    endtask

    task automatic test_fairness();
        logic [3:0] order [5];
        int at [5];
        logic [3:0] prev;
        int ng;
        logic [3:0] exp_order [5];
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        order = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
        at = '{0, 0, 0, 0, 0};
        do_reset();
        key_valid = 1'b1;
        req = 4'b1111;
        req_msg_valid = 4'b1111;
        req_msg_last = 4'b1111;
        eng.msg_ready = 1'b1;
        eng.hmac_done = 1'b1;
        rst_n = 1'b1;
        ng = 0;
        prev = 4'b0000;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            tick();
            if (gnt !== 4'b0000 && prev === 4'b0000) begin
                order[ng] = gnt;
                at[ng] = c;
                ng++;
            end
            prev = gnt;
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (order[k] !== exp_order[k]) begin n_fail++; $display("[TB] FAIL fair_grant%0d: got %b expected %b", k, order[k], exp_order[k]); end
        end
        n_checks++; if (at[1] - at[0] !== 4) begin n_fail++; $display("[TB] FAIL fair_spacing: got %0d cycles expected 4", at[1] - at[0]); end
        req = 4'b0000;
        repeat (6) tick();
        eng.hmac_done = 1'b0;
    endtask

    task automatic test_key_gating();
        int bad;
        key_valid = 1'b0;
        req = 4'b0100;
        req_msg_valid = 4'b0100;
        req_msg_last = 4'b0000;
        eng.msg_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (gnt !== 4'b0000 || busy !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("[TB] FAIL key_hold: %0d cycles granted or busy, expected 0", bad); end
        key_valid = 1'b1;
        tick();
        n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("[TB] FAIL key_grant: got %b expected 0100", gnt); end
        tick();
        n_checks++; if (req_msg_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL key_stream_ready: got %b expected 0100", req_msg_ready); end
        key_valid = 1'b0;
        tick();
        n_checks++; if (rsp_err !== 4'b0100 || rsp_done !== 4'b0000) begin n_fail++; $display("[TB] FAIL key_abort: err %b done %b expected 0100 0000", rsp_err, rsp_done); end
        n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL key_abort_idle: gnt %b busy %b expected 0000 0", gnt, busy); end
        tick();
        n_checks++; if (rsp_err !== 4'b0000 || gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL key_abort_pulse: err %b gnt %b expected 0000 0000", rsp_err, gnt); end
        req = 4'b0000;
    endtask

    task automatic test_watchdog();
        logic [511:0] v2;
        v2 = {16{32'h0BAD0002}};
        do_reset();
        key_valid = 1'b1;
        req = 4'b0001;
        req_msg_valid = 4'b0001;
        req_msg_last = 4'b0001;
        req_msg_word = '0;
        req_msg_word[31:0] = 32'hCAFE0001;
        weng.msg_ready = 1'b1;
        weng.hmac_done = 1'b0;
        weng.hmac_value = '0;
        eng.hmac_done = 1'b0;
        rst_n = 1'b1;
        tick();
        n_checks++; if (weng.start_hmac !== 1'b1 || w_gnt !== 4'b0001) begin n_fail++; $display("[TB] FAIL wd_start: start %b gnt %b expected 1 0001", weng.start_hmac, w_gnt); end
        tick();
        n_checks++; if (weng.msg_valid !== 1'b1 || weng.msg_last !== 1'b1 || weng.msg_word !== 32'hCAFE0001 || w_req_msg_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL wd_stream: valid %b last %b word %h ready %b expected 1 1 cafe0001 0001", weng.msg_valid, weng.msg_last, weng.msg_word, w_req_msg_ready); end
        req = 4'b0000;
        tick();
        repeat (15) tick();
        n_checks++; if (w_rsp_err !== 4'b0000 || w_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL wd_early: err %b busy %b expected 0000 1", w_rsp_err, w_busy); end
        tick();
        n_checks++; if (w_rsp_err !== 4'b0001 || w_rsp_done !== 4'b0000 || w_gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL wd_expire: err %b done %b gnt %b expected 0001 0000 0000", w_rsp_err, w_rsp_done, w_gnt); end
        weng.hmac_done = 1'b1;
        weng.hmac_value = {16{32'hDEAD0000}};
        tick();
        weng.hmac_done = 1'b0;
        n_checks++; if (w_rsp_done !== 4'b0000 || w_busy !== 1'b0 || w_rsp_hmac !== 512'd0) begin n_fail++; $display("[TB] FAIL wd_late_done: done %b busy %b expected 0000 0 with hmac unchanged", w_rsp_done, w_busy); end
        req = 4'b0001;
        tick();
        tick();
        req = 4'b0000;
        tick();
        repeat (15) tick();
        weng.hmac_value = v2;
        weng.hmac_done = 1'b1;
        tick();
        weng.hmac_done = 1'b0;
        n_checks++; if (w_rsp_done !== 4'b0001 || w_rsp_err !== 4'b0000) begin n_fail++; $display("[TB] FAIL wd_tie: done %b err %b expected 0001 0000", w_rsp_done, w_rsp_err); end
        n_checks++; if (w_rsp_hmac !== v2) begin n_fail++; $display("[TB] FAIL wd_tie_hmac: got %h expected %h", w_rsp_hmac, v2); end
    endtask

    task automatic test_backpressure();
        logic [31:0]  words [3];
        logic [31:0]  got [3];
        logic [511:0] v3;
        int n, idx, ncyc, bad_ready;
        bit fin;
        words = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2};
        got   = '{32'h0, 32'h0, 32'h0};
        v3    = {16{32'hC0DE0003}};
        do_reset();
        key_valid = 1'b1;
        req = 4'b1000;
        req_msg_valid = 4'b1111;
        req_msg_last = 4'b0000;
        req_msg_word = '0;
        req_msg_word[127:96] = words[0];
        eng.msg_ready = 1'b1;
        eng.hmac_done = 1'b0;
        eng.hmac_value = v3;
        rst_n = 1'b1;
        tick();
        n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("[TB] FAIL bp_grant: got %b expected 1000", gnt); end
        tick();
        req = 4'b0000;
        n = 0; idx = 0; ncyc = 0; bad_ready = 0; fin = 1'b0;
        while (!fin && ncyc < 30) begin
            eng.msg_ready = (ncyc % 3 == 0);
            #1;
            if (req_msg_ready !== (eng.msg_ready ? 4'b1000 : 4'b0000)) bad_ready++;
            if (eng.msg_valid === 1'b1 && eng.msg_ready === 1'b1) begin
                if (n < 3) got[n] = eng.msg_word;
                n++;
                idx++;
                if (eng.msg_last === 1'b1) fin = 1'b1;
            end
            ncyc++;
            tick();
            if (!fin && idx < 3) begin
                req_msg_word[127:96] = words[idx];
                req_msg_last[3] = (idx == 2);
            end
        end
        n_checks++; if (bad_ready !== 0) begin n_fail++; $display("[TB] FAIL bp_ready: %0d cycles wrong req_msg_ready, expected 0", bad_ready); end
        n_checks++; if (n !== 3 || ncyc !== 7) begin n_fail++; $display("[TB] FAIL bp_beats: got %0d beats in %0d cycles expected 3 in 7", n, ncyc); end
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (got[k] !== words[k]) begin n_fail++; $display("[TB] FAIL bp_word%0d: got %h expected %h", k, got[k], words[k]); end
        end
        eng.msg_ready = 1'b1;
        eng.hmac_done = 1'b1;
        tick();
        eng.hmac_done = 1'b0;
        n_checks++; if (rsp_done !== 4'b1000 || rsp_hmac !== v3) begin n_fail++; $display("[TB] FAIL bp_done: done %b hmac %h expected 1000 %h", rsp_done, rsp_hmac, v3); end
        tick();
    endtask

    task automatic test_reset_mid_stream();
        key_valid = 1'b1;
        req = 4'b0100;
        req_msg_valid = 4'b0100;
        req_msg_last = 4'b0000;
        req_msg_word[95:64] = 32'h5A5A5A5A;
        eng.msg_ready = 1'b1;
        eng.hmac_done = 1'b0;
        tick();
        tick();
        n_checks++; if (eng.msg_valid !== 1'b1 || busy !== 1'b1 || gnt !== 4'b0100) begin n_fail++; $display("[TB] FAIL rms_stream: valid %b busy %b gnt %b expected 1 1 0100", eng.msg_valid, busy, gnt); end
        rst_n = 1'b0;
        tick();
        n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || eng.start_hmac !== 1'b0) begin n_fail++; $display("[TB] FAIL rms_regs: gnt %b busy %b start %b expected 0000 0 0", gnt, busy, eng.start_hmac); end
        n_checks++; if (rsp_done !== 4'b0000 || rsp_err !== 4'b0000 || rsp_hmac !== 512'd0) begin n_fail++; $display("[TB] FAIL rms_rsp: done %b err %b hmac %h expected all zero", rsp_done, rsp_err, rsp_hmac); end
        n_checks++; if (eng.msg_valid !== 1'b0 || eng.msg_last !== 1'b0 || eng.msg_word !== 32'd0 || req_msg_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL rms_msg: valid %b last %b word %h ready %b expected all zero", eng.msg_valid, eng.msg_last, eng.msg_word, req_msg_ready); end
        rst_n = 1'b1;
        req = 4'b0001;
        req_msg_valid = 4'b0001;
        tick();
        n_checks++; if (gnt !== 4'b0001 || eng.start_hmac !== 1'b1) begin n_fail++; $display("[TB] FAIL rms_regrant: gnt %b start %b expected 0001 1", gnt, eng.start_hmac); end
        req = 4'b0000;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        $display("[TB] hmac_req_arbiter bench starting");
        test_reset();
        test_single();
        test_fairness();
        test_key_gating();
        test_watchdog();
        test_backpressure();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
